// File: rtl/iter_shifter_pkg.sv
// Shared definitions for the iterative shift unit: shift-mode codes and FSM states.
package shift_pkg;

   localparam logic [1:0] SH_SLL  = 2'b00;
   localparam logic [1:0] SH_SRL  = 2'b01;
   localparam logic [1:0] SH_ROTR = 2'b10;
   localparam logic [1:0] SH_SRA  = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_SHIFT = 2'b01,
      ST_DONE  = 2'b10
   } state_t;

endpackage

// File: rtl/iter_shifter_if.sv
// Request/response bundle of the iterative shifter: start/done handshake plus operands and result.
interface iter_shifter_if #(
   parameter int WIDTH = 32
) ();
   localparam int SHAMT_W = $clog2(WIDTH);

   logic               start;
   logic [WIDTH-1:0]   data;
   logic [SHAMT_W-1:0] shamt;
   logic [1:0]         mode;
   logic               busy;
   logic               done;
   logic [WIDTH-1:0]   result;

   modport master (
      output start, data, shamt, mode,
      input  busy, done, result
   );

   modport slave (
      input  start, data, shamt, mode,
      output busy, done, result
   );
endinterface

// File: rtl/iter_shifter_step.sv
// Combinational shift of a value by 0..STEP positions in one of the four shift modes.
module step_shifter
   import shift_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int STEP  = 2,
   parameter int AMT_W = $clog2(STEP + 1)
) (
   input  logic [WIDTH-1:0] value,
   input  logic [AMT_W-1:0] amt,
   input  logic [1:0]       mode,
   output logic [WIDTH-1:0] shifted
);

   // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
   always_comb begin
      shifted = value;
      if (amt != '0) begin
         case (mode)
            SH_SLL:  shifted = value << amt;
            SH_SRL:  shifted = value >> amt;
            SH_SRA:  shifted = WIDTH'($signed(value) >>> amt);
            SH_ROTR: shifted = (value >> amt) | (value << (WIDTH - int'(amt)));
            default: shifted = value;
         endcase
      end
   end

endmodule

// File: rtl/iter_shifter.sv
// Multi-cycle SLL/SRL/SRA/ROTR unit: shifts up to STEP bits per clock under a start/done handshake.
module iter_shifter
   import shift_pkg::*;
#(
   parameter  int WIDTH   = 32,
   parameter  int STEP    = 2,
   localparam int SHAMT_W = $clog2(WIDTH)
) (
   input  logic           clk,
   input  logic           rst_n,
   iter_shifter_if.slave  bus
);

   localparam int AMT_W = $clog2(STEP + 1);

   state_t             state, next_state;
   logic [WIDTH-1:0]   work;
   logic [SHAMT_W-1:0] rem, rem_next;
   logic [1:0]         mode_q;
   logic [WIDTH-1:0]   result_q;
   logic [AMT_W-1:0]   step_amt;
   logic [WIDTH-1:0]   shifted;
   logic               accept;

   assign accept = (state != ST_SHIFT) && bus.start;

   // Clamp the per-clock distance so the final partial step never drives rem below zero.
   always_comb begin
      step_amt = AMT_W'(rem);
      if (rem > SHAMT_W'(STEP)) step_amt = AMT_W'(STEP);
      rem_next = rem - SHAMT_W'(step_amt);
   end

   step_shifter #(
      .WIDTH (WIDTH),
      .STEP  (STEP),
      .AMT_W (AMT_W)
   ) u_step (
      .value   (work),
      .amt     (step_amt),
      .mode    (mode_q),
      .shifted (shifted)
   );

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         ST_IDLE, ST_DONE: begin
            next_state = ST_IDLE;
            if (bus.start) next_state = (bus.shamt != '0) ? ST_SHIFT : ST_DONE;
         end
         ST_SHIFT: next_state = (rem_next == '0) ? ST_DONE : ST_SHIFT;
         default:  next_state = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         work     <= '0;
         rem      <= '0;
         mode_q   <= SH_SLL;
         result_q <= '0;
      end else begin
         if (accept) begin
            work   <= bus.data;
            rem    <= bus.shamt;
            mode_q <= bus.mode;
         end else if (state == ST_SHIFT) begin
            work <= shifted;
            rem  <= rem_next;
         end
         // A zero-distance request enters DONE straight from the operand bus.
         if (next_state == ST_DONE)
            result_q <= (state == ST_SHIFT) ? shifted : bus.data;
      end
   end

   always_comb begin
      bus.busy   = (state == ST_SHIFT);
      bus.done   = (state == ST_DONE);
      bus.result = result_q;
   end

endmodule

// File: tb/tb_iter_shifter.sv
// Self-checking bench for iter_shifter (WIDTH=32, STEP=2): vector table, random ops, handshake corners.
module tb_iter_shifter;
   import shift_pkg::*;

   localparam int W    = 32;
   localparam int STEP = 2;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   iter_shifter_if #(.WIDTH(W)) bus ();

   iter_shifter #(.WIDTH(W), .STEP(STEP)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int checks   = 0;
   int failures = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Reference: bit-level definition of each shift mode.
   function automatic logic [31:0] ref_shift(input logic [1:0] m, input logic [31:0] d, input int s);
      logic [31:0] r;
      r = '0;
      for (int i = 0; i < W; i++) begin
         case (m)
            SH_SLL:  r[i] = (i >= s) ? d[i - s] : 1'b0;
            SH_SRL:  r[i] = (i + s < W) ? d[i + s] : 1'b0;
            SH_SRA:  r[i] = (i + s < W) ? d[i + s] : d[W-1];
            default: r[i] = d[(i + s) % W];
         endcase
      end
      return r;
   endfunction

   function automatic int ref_edges(input int s);
      return (s + STEP - 1) / STEP + 1;
   endfunction

   // Issues one request and counts edges until done; scrambles inputs while the unit is busy.
   task automatic run_op(input logic [1:0] m, input logic [31:0] d, input int s,
                         output logic [31:0] res, output int edges, output int busy_cyc);
      @(negedge clk);
      bus.start = 1'b1; bus.mode = m; bus.data = d; bus.shamt = 5'(s);
      @(posedge clk); #1;
      bus.start = 1'b0;
      edges = 1; busy_cyc = 0;
      while (!bus.done && edges < 100) begin
         if (bus.busy) busy_cyc++;
         bus.data = $urandom; bus.shamt = 5'($urandom); bus.mode = 2'($urandom);
         @(posedge clk); #1;
         edges++;
      end
      res = bus.result;
   endtask

   task automatic wait_done(input int max_edges, inout int edges);
      while (!bus.done && edges < max_edges) begin
         @(posedge clk); #1;
         edges++;
      end
   endtask

   typedef struct {
      logic [1:0]  mode;
      logic [31:0] data;
      int          shamt;
      logic [31:0] exp_res;
      int          exp_edges;
   } vec_t;

   vec_t vecs[7];

   initial begin
      logic [31:0] res;
      int edges, busy_cyc, s;
      logic [1:0] m;
      logic [31:0] d;
      bit saw_done;

      vecs[0] = '{SH_SRL,  32'h8000_0000, 31, 32'h0000_0001, 17};
      vecs[1] = '{SH_SRA,  32'h8000_0000,  4, 32'hF800_0000,  3};
      vecs[2] = '{SH_SRA,  32'h4000_0000,  4, 32'h0400_0000,  3};
      vecs[3] = '{SH_SLL,  32'h0000_0001,  0, 32'h0000_0001,  1};
      vecs[4] = '{SH_ROTR, 32'h0000_0003,  1, 32'h8000_0001,  2};
      vecs[5] = '{SH_ROTR, 32'h1234_5678, 31, 32'h2468_ACF0, 17};
      vecs[6] = '{SH_SLL,  32'hFFFF_FFFF, 31, 32'h8000_0000, 17};

      rst_n = 1'b0;
      bus.start = 1'b0; bus.data = '0; bus.shamt = '0; bus.mode = SH_SLL;
      #12;
      check("reset_busy",   32'(bus.busy),   32'd0);
      check("reset_done",   32'(bus.done),   32'd0);
      check("reset_result", bus.result,      32'd0);
      @(negedge clk); rst_n = 1'b1;

      foreach (vecs[i]) begin
         run_op(vecs[i].mode, vecs[i].data, vecs[i].shamt, res, edges, busy_cyc);
         check($sformatf("vec%0d_result", i), res, vecs[i].exp_res);
         check($sformatf("vec%0d_edges", i), 32'(edges), 32'(vecs[i].exp_edges));
         check($sformatf("vec%0d_busy", i), 32'(busy_cyc), 32'(vecs[i].exp_edges - 1));
         @(posedge clk); #1;
         check($sformatf("vec%0d_done_pulse", i), 32'(bus.done), 32'd0);
         check($sformatf("vec%0d_hold", i), bus.result, vecs[i].exp_res);
      end

      for (int i = 0; i < 40; i++) begin
         m = 2'($urandom_range(0, 3));
         d = $urandom;
         s = $urandom_range(0, W - 1);
         run_op(m, d, s, res, edges, busy_cyc);
         check($sformatf("rnd%0d_result m=%0d s=%0d", i, m, s), res, ref_shift(m, d, s));
         check($sformatf("rnd%0d_edges", i), 32'(edges), 32'(ref_edges(s)));
         check($sformatf("rnd%0d_busy", i), 32'(busy_cyc), 32'(ref_edges(s) - 1));
      end

      // Start ignored while busy, then a back-to-back request during DONE.
      @(posedge clk); @(negedge clk);
      bus.start = 1'b1; bus.mode = SH_SLL; bus.data = 32'h1; bus.shamt = 5'd5;
      @(posedge clk); #1; bus.start = 1'b0; edges = 1;
      @(negedge clk);
      bus.start = 1'b1; bus.mode = SH_SRL; bus.data = 32'hFFFF; bus.shamt = 5'd1;
      @(posedge clk); #1; bus.start = 1'b0; edges++;
      check("b2b_busy_mid", 32'(bus.busy), 32'd1);
      wait_done(50, edges);
      check("b2b_a_edges", 32'(edges), 32'd4);
      check("b2b_a_result", bus.result, 32'h0000_0020);
      bus.start = 1'b1; bus.mode = SH_SRL; bus.data = 32'hF0; bus.shamt = 5'd4;
      @(posedge clk); #1; bus.start = 1'b0; edges = 1;
      check("b2b_b_accepted", 32'(bus.busy), 32'd1);
      check("b2b_b_hold_a", bus.result, 32'h0000_0020);
      wait_done(50, edges);
      check("b2b_b_edges", 32'(edges), 32'd3);
      check("b2b_b_result", bus.result, 32'h0000_000F);

      // Reset during an operation.
      @(posedge clk); @(negedge clk);
      bus.start = 1'b1; bus.mode = SH_SRL; bus.data = 32'hFFFF_FFFF; bus.shamt = 5'd20;
      @(posedge clk); #1; bus.start = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("rst_pre_busy", 32'(bus.busy), 32'd1);
      rst_n = 1'b0;
      #1;
      check("rst_busy",   32'(bus.busy), 32'd0);
      check("rst_done",   32'(bus.done), 32'd0);
      check("rst_result", bus.result,    32'd0);
      @(negedge clk); rst_n = 1'b1;
      saw_done = 1'b0;
      for (int i = 0; i < 15; i++) begin
         @(posedge clk); #1;
         if (bus.done) saw_done = 1'b1;
      end
      check("rst_no_done", 32'(saw_done), 32'd0);
      run_op(SH_SRA, 32'h8000_00F0, 7, res, edges, busy_cyc);
      check("post_rst_result", res, ref_shift(SH_SRA, 32'h8000_00F0, 7));
      check("post_rst_edges", 32'(edges), 32'(ref_edges(7)));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/iter_shifter.md
Name: iter_shifter

Overview:
Multi-cycle, parametrised shift unit for the MIPS32 datapath. It is the successor to the fixed shift-by-2 right shifter. It handles SLL/SRL/SRA/ROTR with a variable shift amount. It shifts STEP bit positions per clock and uses a start/done handshake. The EX stage instantiates it for variable shifts, where area matters more than single-cycle latency.

Parameters:
WIDTH, 32, data width in bits (>= 2)
STEP, 2, maximum shift distance per clock (1..WIDTH-1)
SHAMT_W, $clog2(WIDTH), shift-amount width (derived; not overridden)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only when not busy
data  input  WIDTH  operand, captured on accepted start
shamt  input  SHAMT_W  shift distance, captured on accepted start
mode  input  2  00 SLL, 01 SRL, 11 SRA, 10 ROTR (rotate right); captured on accepted start
busy  output  1  high while shifting
done  output  1  one-cycle pulse when result becomes valid
result  output  WIDTH  shifted value; held until the next completion

Behaviour:
- Reset is asserted asynchronously with rst_n=0. Reset state: state=IDLE, busy=0, done=0, result=0, internal work reg=0, remaining count=0.
- States are IDLE, SHIFT and DONE.
- IDLE or DONE with start=1 at an edge:
  - Capture data into work reg, shamt into rem, and mode.
  - Next state is SHIFT if shamt!=0, else DONE.
- SHIFT, at each edge:
  - k = min(STEP, rem).
  - Work reg is shifted by k per mode:
    - SLL: zero-fill from the LSB.
    - SRL: zero-fill from the MSB.
    - SRA: fill with the captured MSB.
    - ROTR: bits leaving the LSB re-enter at the MSB.
  - rem <= rem-k.
  - If rem-k==0, next state is DONE; else stay in SHIFT.
- DONE lasts exactly one cycle:
  - done=1 and result=work reg, driven from registers with no combinational path from the inputs.
  - Without start, the next state is IDLE.
  - With start, a new operation is accepted (back-to-back operation), per the IDLE rule.
- busy=1 exactly in SHIFT. start is ignored while busy=1, and inputs may change freely during SHIFT.
- Latency: done is high in the cycle following edge number ceil(shamt/STEP)+1, counted from the accepting edge (edge 1).
  - shamt=0 gives done after 1 edge, with result=data.
  - Throughput is one operation per ceil(shamt/STEP)+1 cycles.
- Boundaries:
  - shamt=WIDTH-1 is legal.
  - rem never underflows, because k is clamped.
  - A final partial step (rem<STEP) shifts by rem only.
  - mode is frozen for the whole operation.
- Reset mid-operation aborts with no done pulse. result returns to 0.
- result updates only on the DONE entry edge. Between operations it holds the last value.

Decomposition:
- Shared package `shift_pkg`:
  - mode localparams SH_SLL=2'b00, SH_SRL=2'b01, SH_ROTR=2'b10, SH_SRA=2'b11;
  - state encoding constants.
- Sub-module `step_shifter`: purely combinational. Inputs are the WIDTH-bit value, an amount of 0..STEP and the mode; output is the value shifted by that amount. It is the generalised replacement for the fixed right-by-2 shifter. It is instantiated once; the FSM and counter live in iter_shifter.

Test Plan:
1. WIDTH=32, STEP=2, SRL, data=0x80000000, shamt=31 -> busy high for 16 cycles, done after edge 17, result=0x00000001.
2. SRA, data=0x80000000, shamt=4 -> done after edge 3, result=0xF8000000. Repeat with data=0x40000000 -> result=0x04000000.
3. SLL, data=0x00000001, shamt=0 -> busy never high, done after edge 1, result=0x00000001.
4. ROTR, data=0x00000003, shamt=1 -> done after edge 2, result=0x80000001.
5. Busy protection and back-to-back:
   - Start op A (SLL, 0x1, shamt=5).
   - Pulse start with different operands mid-SHIFT; it is ignored. A completes with 0x00000020.
   - Assert start during A's DONE cycle with SRL 0xF0, shamt=4. That op is accepted and later yields 0x0000000F.
6. Reset mid-operation: SRL 0xFFFFFFFF, shamt=20, drop rst_n at cycle 3 -> busy, done and result go to 0 immediately. No done pulse occurs after release. A new start then operates normally.
